// File: rtl/mem_bus_guard_pkg.sv
// mem_bus_guard_pkg: shared state type, constants and helpers for the memory bus guard
package mem_bus_guard_pkg;

    // Word returned for aborted accesses; equals the illegal-instruction encoding so a dead fetch traps
    localparam logic [31:0] ILLEGAL_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_bus_guard_if.sv
// mem_bus_guard_if: picorv32-style memory request/response bundle
interface mem_bus_guard_if;

    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master(output valid, instr, addr, wdata, wstrb, input rdata, ready);
    modport slave (input valid, instr, addr, wdata, wstrb, output rdata, ready);

endinterface

// File: rtl/mem_bus_guard.sv
// mem_bus_guard: registered CPU-to-decoder stage with a watchdog that aborts unanswered accesses
module mem_bus_guard
    import mem_bus_guard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_RDATA    = ILLEGAL_INSTR
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_bus_guard_if.slave  cpu,
    mem_bus_guard_if.master bus,
    input  logic            clear_status,
    output logic            timeout_flag,
    output logic [31:0]     timeout_addr,
    output logic [7:0]      timeout_count
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] wd_q, wd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        flag_q, flag_d;
    logic [31:0] taddr_q, taddr_d;
    logic [7:0]  count_q, count_d;

    assign bus.valid     = (state_q == ISSUE);
    assign bus.instr     = instr_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign cpu.ready     = (state_q == RESP);
    assign cpu.rdata     = rdata_q;
    assign timeout_flag  = flag_q;
    assign timeout_addr  = taddr_q;
    assign timeout_count = count_q;

    // Next state: request capture, watchdog, response selection and sticky status (an abort overrides a same-cycle clear)
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        flag_d  = clear_status ? 1'b0 : flag_q;
        taddr_d = clear_status ? 32'h0 : taddr_q;
        count_d = clear_status ? 8'h0 : count_q;
        case (state_q)
            IDLE: if (cpu.valid) begin
                instr_d = cpu.instr;
                addr_d  = cpu.addr;
                wdata_d = cpu.wdata;
                wstrb_d = cpu.wstrb;
                wd_d    = 16'h0;
                state_d = ISSUE;
            end
            ISSUE: begin
                wd_d = wd_q + 16'd1;
                if (bus.ready) begin
                    rdata_d = bus.rdata;
                    state_d = RESP;
                end else if (wd_q == TO_LAST) begin
                    rdata_d = ERROR_RDATA;
                    flag_d  = 1'b1;
                    taddr_d = addr_q;
                    count_d = sat_inc8(clear_status ? 8'h0 : count_q);
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wd_q    <= 16'h0;
            rdata_q <= 32'h0;
            instr_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            flag_q  <= 1'b0;
            taddr_q <= 32'h0;
            count_q <= 8'h0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            flag_q  <= flag_d;
            taddr_q <= taddr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_guard.sv
// tb_mem_bus_guard: directed scoreboard bench for the memory bus guard
module tb_mem_bus_guard;
    import mem_bus_guard_pkg::*;

    localparam int T = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        flag;
        logic [31:0] addr;
        logic [7:0]  count;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        clear_status;
    logic        timeout_flag;
    logic [31:0] timeout_addr;
    logic [7:0]  timeout_count;

    mem_bus_guard_if cpu();
    mem_bus_guard_if bus();

    mem_bus_guard #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu          (cpu),
        .bus          (bus),
        .clear_status (clear_status),
        .timeout_flag (timeout_flag),
        .timeout_addr (timeout_addr),
        .timeout_count(timeout_count)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic        m_flag  = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    logic [7:0]  m_count = 8'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every cpu_ready must match the oldest queued expectation
    always @(negedge clk) begin
        if (cpu.ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=1 expected=0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", cpu.rdata, e.rdata);
                chk("resp_flag", {31'h0, timeout_flag}, {31'h0, e.flag});
                chk("resp_taddr", timeout_addr, e.addr);
                chk("resp_count", {24'h0, timeout_count}, {24'h0, e.count});
            end
        end
    end

    // One access starting in an IDLE cycle; rdy_at = ISSUE cycle with bus_ready (0 = never), clr_at = cycle with clear_status
    task automatic access(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int rdy_at, input logic [31:0] rd, input int clr_at);
        int cyc;
        int exp_cyc;
        bit done;
        bit abort;
        abort   = (rdy_at == 0 || rdy_at > T);
        exp_cyc = abort ? T + 1 : rdy_at + 1;
        if (clr_at != 0) begin
            m_flag  = 1'b0;
            m_addr  = 32'h0;
            m_count = 8'h0;
        end
        if (abort) begin
            m_flag  = 1'b1;
            m_addr  = addr;
            m_count = (m_count == 8'hff) ? 8'hff : m_count + 8'd1;
        end
        sb.push_back('{abort ? 32'h0 : rd, m_flag, m_addr, m_count});
        cpu.valid = 1'b1;
        cpu.instr = instr;
        cpu.addr  = addr;
        cpu.wdata = wdata;
        cpu.wstrb = wstrb;
        cyc  = 0;
        done = 0;
        while (!done && cyc < T + 6) begin
            @(posedge clk);
            #1;
            cyc++;
            cpu.valid    = 1'b0;
            cpu.instr    = ~instr;
            cpu.addr     = ~addr;
            cpu.wdata    = ~wdata;
            cpu.wstrb    = ~wstrb;
            bus.ready    = 1'b0;
            clear_status = 1'b0;
            if (cpu.ready === 1'b1) begin
                done = 1;
                chk("resp_cycle", 32'(cyc), 32'(exp_cyc));
                chk("resp_bus_valid", {31'h0, bus.valid}, 32'h0);
            end else begin
                chk("issue_valid", {31'h0, bus.valid}, 32'h1);
                chk("issue_addr", bus.addr, addr);
                if (bus.wdata !== wdata || bus.wstrb !== wstrb || bus.instr !== instr)
                    chk("issue_fields", {bus.wdata[27:0], bus.wstrb}, {wdata[27:0], wstrb});
                if (cyc == rdy_at) begin
                    bus.ready = 1'b1;
                    bus.rdata = rd;
                end
                if (cyc == clr_at) clear_status = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=no_ready expected=ready_by_cycle_%0d", exp_cyc);
        end
        @(posedge clk);
        #1;
        chk("single_ready", {31'h0, cpu.ready}, 32'h0);
    endtask

    task automatic status_is(input logic f, input logic [31:0] a, input logic [7:0] c);
        chk("status_flag", {31'h0, timeout_flag}, {31'h0, f});
        chk("status_addr", timeout_addr, a);
        chk("status_count", {24'h0, timeout_count}, {24'h0, c});
    endtask

    task automatic clear_idle();
        clear_status = 1'b1;
        @(posedge clk);
        #1;
        clear_status = 1'b0;
        m_flag  = 1'b0;
        m_addr  = 32'h0;
        m_count = 8'h0;
        status_is(1'b0, 32'h0, 8'h0);
    endtask

    initial begin
        reset_n      = 1'b0;
        clear_status = 1'b0;
        cpu.valid    = 1'b0;
        cpu.instr    = 1'b0;
        cpu.addr     = 32'h0;
        cpu.wdata    = 32'h0;
        cpu.wstrb    = 4'h0;
        bus.ready    = 1'b0;
        bus.rdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_bus_valid", {31'h0, bus.valid}, 32'h0);
        chk("rst_cpu_ready", {31'h0, cpu.ready}, 32'h0);
        chk("rst_cpu_rdata", cpu.rdata, 32'h0);
        chk("rst_bus_addr", bus.addr, 32'h0);
        chk("rst_bus_wdata", {bus.wdata[27:0], bus.wstrb}, 32'h0);
        status_is(1'b0, 32'h0, 8'h0);

        access(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3, 32'hdeadbeef, 0);
        access(1'b0, 32'h4000_0010, 32'h1234_5678, 4'hf, 2, 32'h0, 0);
        access(1'b1, 32'h0000_0200, 32'h0, 4'h0, 1, 32'h0000_0013, 0);
        status_is(1'b0, 32'h0, 8'h0);

        access(1'b0, 32'hc500_0000, 32'h0, 4'h0, 0, 32'h0, 0);
        status_is(1'b1, 32'hc500_0000, 8'd1);

        access(1'b0, 32'h1000_0004, 32'h0, 4'h0, T, 32'hcafe_f00d, 0);
        access(1'b0, 32'h1000_0008, 32'h0, 4'h0, T - 1, 32'h0bad_f00d, 0);
        status_is(1'b1, 32'hc500_0000, 8'd1);

        clear_idle();

        for (int i = 0; i < 300; i++)
            access(1'b0, 32'h8000_0000 + 32'(i * 4), 32'h5555_aaaa, 4'h3, 0, 32'h0, 0);
        status_is(1'b1, 32'h8000_04ac, 8'd255);
        clear_idle();

        access(1'b0, 32'hc600_0000, 32'h0, 4'h0, 0, 32'h0, 0);
        access(1'b0, 32'hc700_0000, 32'h0, 4'h0, 0, 32'h0, T);
        status_is(1'b1, 32'hc700_0000, 8'd1);

        bus.ready = 1'b1;
        bus.rdata = 32'h7777_7777;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("idle_ready_ignored", {31'h0, cpu.ready}, 32'h0);
        end
        bus.ready = 1'b0;

        cpu.valid = 1'b1;
        cpu.addr  = 32'h2000_0000;
        cpu.wstrb = 4'h0;
        @(posedge clk);
        #1;
        cpu.valid = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_flag  = 1'b0;
        m_addr  = 32'h0;
        m_count = 8'h0;
        chk("reset_bus_valid", {31'h0, bus.valid}, 32'h0);
        chk("reset_cpu_ready", {31'h0, cpu.ready}, 32'h0);
        status_is(1'b0, 32'h0, 8'h0);
        repeat (2) @(posedge clk);
        #1;

        access(1'b0, 32'h3000_0000, 32'h0, 4'h0, 2, 32'h1357_9bdf, 0);
        access(1'b0, 32'h3000_0004, 32'hffff_0000, 4'h3, 1, 32'h0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
